// File: rtl/fpga_platform_shell_if.sv
// Board-facing control pins of the platform shell: flash strobes, PMU pads, JTAG and the LF clock.
// The shell drives through the master modport; the board or bench uses the slave modport.
interface fpga_platform_shell_if;
  logic CLK32768KHZ;
  logic qspi_cs;
  logic qspi_sck;
  logic mcu_TCK;
  logic mcu_TMS;
  logic mcu_TDI;
  logic mcu_TDO;
  logic pmu_paden;
  logic pmu_padrst;
  logic mcu_wakeup;

  modport master (
    output CLK32768KHZ,
    output qspi_cs,
    output qspi_sck,
    output mcu_TDO,
    output pmu_paden,
    output pmu_padrst,
    input  mcu_TCK,
    input  mcu_TMS,
    input  mcu_TDI,
    input  mcu_wakeup
  );

  modport slave (
    input  CLK32768KHZ,
    input  qspi_cs,
    input  qspi_sck,
    input  mcu_TDO,
    input  pmu_paden,
    input  pmu_padrst,
    output mcu_TCK,
    output mcu_TMS,
    output mcu_TDI,
    output mcu_wakeup
  );
endinterface

// File: rtl/fpga_platform_shell.sv
// Platform shell: reset/PMU sequencing, QSPI JEDEC-ID probe reported on GPIO,
// 32.768 kHz phase-accumulator clock, wakeup capture and a JTAG bypass bit.
module fpga_platform_shell #(
  parameter int unsigned RST_STRETCH = 16,
  parameter int unsigned SCK_HALF    = 2,
  parameter logic [31:0] LF_INC      = 32'd1407375
) (
  input  logic                  CLK100MHZ,
  input  logic                  fpga_rst,
  input  logic                  mcu_rst,
  fpga_platform_shell_if.master bus,
  inout  wire  [3:0]            qspi_dq,
  inout  wire  [31:0]           gpio
);

  localparam int unsigned CNT_W  = $clog2(RST_STRETCH + 1);
  localparam int unsigned HALF_W = $clog2(SCK_HALF + 1);
  localparam int unsigned BIT_W  = 6;
  localparam int unsigned ID_W   = 24;
  localparam int unsigned NBITS  = 32;
  localparam logic [7:0]  CMD_RDID = 8'h9F;

  typedef enum logic [1:0] {S_RST, S_STRETCH, S_PROBE, S_DONE} state_t;

  logic rst_any;
  assign rst_any = fpga_rst | mcu_rst;

  // Low-frequency clock: free-running phase accumulator, only the board reset touches it.
  logic [31:0] acc_q;
  logic [31:0] acc_d;
  logic        lf_gpio_q;

  assign acc_d = acc_q + LF_INC;

  always_ff @(posedge CLK100MHZ) begin
    if (fpga_rst) acc_q <= '0;
    else          acc_q <= acc_d;
  end

  always_ff @(posedge CLK100MHZ) begin
    if (rst_any) lf_gpio_q <= 1'b0;
    else         lf_gpio_q <= acc_d[31];
  end

  assign bus.CLK32768KHZ = acc_q[31];

  // Synchronizers for the asynchronous wakeup and JTAG pins, plus the bypass bit.
  logic [1:0] wake_sync_q;
  logic       wake_prev_q;
  logic       wake_sticky_q;
  logic [2:0] tck_sync_q;
  logic [1:0] tdi_sync_q;
  logic       bypass_q;
  logic       tdo_q;
  logic       tck_rise;
  logic       tck_fall;
  logic       wake_rise;

  assign tck_rise  =  tck_sync_q[1] & ~tck_sync_q[2];
  assign tck_fall  = ~tck_sync_q[1] &  tck_sync_q[2];
  assign wake_rise =  wake_sync_q[1] & ~wake_prev_q;

  always_ff @(posedge CLK100MHZ) begin
    if (fpga_rst) begin
      wake_sync_q <= '0;
      wake_prev_q <= 1'b0;
      tck_sync_q  <= '0;
      tdi_sync_q  <= '0;
      bypass_q    <= 1'b0;
      tdo_q       <= 1'b0;
    end else begin
      wake_sync_q <= {wake_sync_q[0], bus.mcu_wakeup};
      wake_prev_q <= wake_sync_q[1];
      tck_sync_q  <= {tck_sync_q[1:0], bus.mcu_TCK};
      tdi_sync_q  <= {tdi_sync_q[0], bus.mcu_TDI};
      if (tck_rise) bypass_q <= tdi_sync_q[1];
      if (tck_fall) tdo_q    <= bypass_q;
    end
  end

  // Sync flops keep running through mcu_rst so an edge right at deassertion still lands.
  always_ff @(posedge CLK100MHZ) begin
    if (rst_any)        wake_sticky_q <= 1'b0;
    else if (wake_rise) wake_sticky_q <= 1'b1;
  end

  assign bus.mcu_TDO = tdo_q;

  // Sequencer and flash probe.
  state_t            state_q,  state_d;
  logic [CNT_W-1:0]  cnt_q,    cnt_d;
  logic              cs_q,     cs_d;
  logic              sck_q,    sck_d;
  logic              mosi_q,   mosi_d;
  logic [7:0]        cmd_q,    cmd_d;
  logic [HALF_W-1:0] half_q,   half_d;
  logic [BIT_W-1:0]  bit_q,    bit_d;
  logic [ID_W-1:0]   shift_q,  shift_d;
  logic [ID_W-1:0]   id_q,     id_d;
  logic              done_q,   done_d;
  logic              err_q,    err_d;
  logic              paden_q,  paden_d;
  logic              padrst_q, padrst_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cs_d     = cs_q;
    sck_d    = sck_q;
    mosi_d   = mosi_q;
    cmd_d    = cmd_q;
    half_d   = half_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    id_d     = id_q;
    done_d   = done_q;
    err_d    = err_q;
    paden_d  = paden_q;
    padrst_d = padrst_q;

    case (state_q)
      S_RST: begin
        state_d = S_STRETCH;
        cnt_d   = CNT_W'(1);
      end

      S_STRETCH: begin
        if (cnt_q == CNT_W'(RST_STRETCH - 1)) begin
          state_d  = S_PROBE;
          padrst_d = 1'b0;
          paden_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_PROBE: begin
        if (cs_q) begin
          // First probe cycle: select the flash and present the command MSB.
          cs_d   = 1'b0;
          sck_d  = 1'b0;
          half_d = '0;
          bit_d  = '0;
          mosi_d = CMD_RDID[7];
          cmd_d  = {CMD_RDID[6:0], 1'b0};
        end else if (half_q == HALF_W'(SCK_HALF - 1)) begin
          half_d = '0;
          if (sck_q) begin
            sck_d  = 1'b0;
            bit_d  = bit_q + BIT_W'(1);
            mosi_d = cmd_q[7];
            cmd_d  = {cmd_q[6:0], 1'b0};
          end else if (bit_q == BIT_W'(NBITS)) begin
            cs_d    = 1'b1;
            mosi_d  = 1'b0;
            state_d = S_DONE;
            id_d    = shift_q;
            done_d  = 1'b1;
            err_d   = (shift_q == '0) || (shift_q == '1);
          end else begin
            // Mode 0: sample MISO on the rising SCK edge; 32 samples leave the ID in place.
            sck_d   = 1'b1;
            shift_d = {shift_q[ID_W-2:0], qspi_dq[1]};
          end
        end else begin
          half_d = half_q + HALF_W'(1);
        end
      end

      S_DONE: begin
        state_d = S_DONE;
      end

      default: begin
        state_d = S_RST;
      end
    endcase
  end

  always_ff @(posedge CLK100MHZ) begin
    if (rst_any) begin
      state_q  <= S_RST;
      cnt_q    <= '0;
      cs_q     <= 1'b1;
      sck_q    <= 1'b0;
      mosi_q   <= 1'b0;
      cmd_q    <= '0;
      half_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      id_q     <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      paden_q  <= 1'b0;
      padrst_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cs_q     <= cs_d;
      sck_q    <= sck_d;
      mosi_q   <= mosi_d;
      cmd_q    <= cmd_d;
      half_q   <= half_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      id_q     <= id_d;
      done_q   <= done_d;
      err_q    <= err_d;
      paden_q  <= paden_d;
      padrst_q <= padrst_d;
    end
  end

  assign bus.qspi_cs    = cs_q;
  assign bus.qspi_sck   = sck_q;
  assign bus.pmu_paden  = paden_q;
  assign bus.pmu_padrst = padrst_q;

  // WP#/HOLD# held high, MISO released to the flash.
  assign qspi_dq = {2'b11, 1'bz, mosi_q};
  assign gpio    = {wake_sticky_q, 4'b0000, lf_gpio_q, err_q, done_q, id_q};

  // TMS has no role in a bypass-only chain; the driven pad bits are never read back.
  logic pins_unused;
  assign pins_unused = ^{bus.mcu_TMS, qspi_dq[3:2], qspi_dq[0], gpio};

endmodule

// File: tb/tb_fpga_platform_shell.sv
// Bench for fpga_platform_shell: flash model + scoreboard for probe results,
// closed-form LF clock model, reset sequencing, wakeup and JTAG bypass checks.
`timescale 1ns/1ps
module tb_fpga_platform_shell;

  localparam int unsigned     RST_STRETCH = 16;
  localparam int unsigned     SCK_HALF    = 2;
  localparam longint unsigned LF_INC      = 64'd1407375;
  localparam int unsigned     CS_LOW      = SCK_HALF * (2 * 32 + 1);
  localparam longint unsigned LF_PER_LO   = (64'd1 << 32) / LF_INC;

  logic clk = 1'b0;
  logic fpga_rst;
  logic mcu_rst;
  wire  [3:0]  qspi_dq;
  wire  [31:0] gpio;

  fpga_platform_shell_if bus();

  fpga_platform_shell #(
    .RST_STRETCH(RST_STRETCH),
    .SCK_HALF   (SCK_HALF),
    .LF_INC     (32'(LF_INC))
  ) dut (
    .CLK100MHZ(clk),
    .fpga_rst (fpga_rst),
    .mcu_rst  (mcu_rst),
    .bus      (bus),
    .qspi_dq  (qspi_dq),
    .gpio     (gpio)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp_v);
    end
  endtask

  // Flash model: captures the command on SCK rises, shifts the ID out on SCK falls.
  logic        flash_present = 1'b1;
  logic [23:0] flash_id = 24'h0;
  logic        miso_bit = 1'b0;
  int          rise_cnt = 0;
  logic [7:0]  cmd_seen = 8'h0;
  logic        mosi_tail = 1'b0;

  assign qspi_dq[1] = flash_present ? miso_bit : 1'b1;

  always @(negedge bus.qspi_cs) begin
    rise_cnt  = 0;
    cmd_seen  = 8'h0;
    mosi_tail = 1'b0;
  end

  always @(posedge bus.qspi_sck) begin
    if (!bus.qspi_cs) begin
      if (rise_cnt < 8) cmd_seen = {cmd_seen[6:0], qspi_dq[0]};
      else              mosi_tail = mosi_tail | qspi_dq[0];
      rise_cnt++;
    end
  end

  always @(negedge bus.qspi_sck) begin
    if (!bus.qspi_cs && rise_cnt >= 8 && rise_cnt < 32)
      miso_bit = flash_id[23 - (rise_cnt - 8)];
  end

  // Scoreboard of expected probe results; the monitor pops on each completion.
  typedef struct packed {
    logic [23:0] id;
    logic        err;
  } exp_t;

  exp_t sb_q[$];

  logic done_prev = 1'b0;
  logic cs_prev   = 1'b1;
  logic sck_prev  = 1'b0;
  logic dq0_prev  = 1'b0;
  int   cs_cnt    = 0;
  int   cs_len    = 0;
  int   mosi_viol = 0;

  always @(negedge clk) begin
    exp_t e;
    if (!bus.qspi_cs) cs_cnt++;
    else if (!cs_prev) begin
      cs_len = cs_cnt;
      cs_cnt = 0;
    end
    if (sck_prev && bus.qspi_sck && (qspi_dq[0] !== dq0_prev)) mosi_viol++;
    if (gpio[24] === 1'b1 && !done_prev) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: id=%h with no pending probe", gpio[23:0]);
      end else begin
        e = sb_q.pop_front();
        check("probe_id",    32'(gpio[23:0]), 32'(e.id));
        check("probe_err",   32'(gpio[25]),   32'(e.err));
        check("probe_cs_low", 32'(cs_len),    32'(CS_LOW));
        check("probe_cmd",   32'(cmd_seen),   32'h9F);
        check("probe_mosi_tail", 32'(mosi_tail), 32'h0);
      end
    end
    done_prev = (gpio[24] === 1'b1);
    cs_prev   = bus.qspi_cs;
    sck_prev  = bus.qspi_sck;
    dq0_prev  = qspi_dq[0];
  end

  // LF clock model: after k cycles the number of rises is floor((k*INC + 2^31) / 2^32).
  int   lf_k      = 0;
  int   lf_k_snap = 0;
  int   lf_edges  = 0;
  int   lf_last   = -1;
  logic lf_prev   = 1'b0;

  always @(posedge clk) lf_k <= fpga_rst ? 0 : lf_k + 1;

  always @(negedge clk) begin
    if (lf_k == 0) begin
      lf_edges = 0;
      lf_last  = -1;
    end else if (bus.CLK32768KHZ === 1'b1 && !lf_prev) begin
      lf_edges++;
      if (lf_last >= 0) begin
        n_tests++;
        if (longint'(lf_k - lf_last) != LF_PER_LO && longint'(lf_k - lf_last) != LF_PER_LO + 1) begin
          n_fail++;
          $display("FAIL lf_period: got %0d cycles, expected %0d or %0d", lf_k - lf_last, LF_PER_LO, LF_PER_LO + 1);
        end
      end
      lf_last = lf_k;
    end
    lf_prev   = (bus.CLK32768KHZ === 1'b1);
    lf_k_snap = lf_k;
  end

  // TDO may only move while TCK is low.
  logic tdo_prev = 1'b0;
  int   tdo_viol = 0;
  always @(negedge clk) begin
    if (bus.mcu_TCK === 1'b1 && bus.mcu_TDO !== tdo_prev) tdo_viol++;
    tdo_prev = bus.mcu_TDO;
  end

  task automatic start_probe(input logic present, input logic [23:0] id);
    exp_t e;
    flash_present = present;
    flash_id      = id;
    e.id  = present ? id : 24'hFFFFFF;
    e.err = (e.id == 24'h000000) || (e.id == 24'hFFFFFF);
    sb_q.push_back(e);
    mcu_rst = 1'b1;
    repeat (2) @(negedge clk);
    mcu_rst = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (gpio[24] !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (gpio[24] !== 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: done=%b after %0d cycles, required 1", name, gpio[24], n);
    end
  endtask

  initial begin
    int n;
    logic [3:0] pat;
    longint unsigned lf_exp;

    fpga_rst       = 1'b1;
    mcu_rst        = 1'b0;
    bus.mcu_TCK    = 1'b0;
    bus.mcu_TMS    = 1'b0;
    bus.mcu_TDI    = 1'b0;
    bus.mcu_wakeup = 1'b0;
    flash_present  = 1'b1;
    flash_id       = 24'hEF4018;

    repeat (10) @(posedge clk);
    @(negedge clk);
    check("rst_lfclk",  32'(bus.CLK32768KHZ), 32'h0);
    check("rst_cs",     32'(bus.qspi_cs),     32'h1);
    check("rst_sck",    32'(bus.qspi_sck),    32'h0);
    check("rst_dq0",    32'(qspi_dq[0]),      32'h0);
    check("rst_gpio",   gpio,                 32'h0);
    check("rst_tdo",    32'(bus.mcu_TDO),     32'h0);
    check("rst_paden",  32'(bus.pmu_paden),   32'h0);
    check("rst_padrst", 32'(bus.pmu_padrst),  32'h1);

    start_probe(1'b1, 24'hEF4018);
    fpga_rst = 1'b0;
    n = 0;
    while (bus.pmu_padrst === 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("padrst_delay",   32'(n),              32'(RST_STRETCH));
    check("paden_at_release", 32'(bus.pmu_paden), 32'h1);
    wait_done("first_probe");

    // Abort a probe part-way through with mcu_rst, then let it re-probe.
    start_probe(1'b1, 24'($urandom()));
    n = 0;
    while (bus.qspi_cs !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("abort_cs_started", 32'(bus.qspi_cs), 32'h0);
    repeat (60) @(negedge clk);
    mcu_rst = 1'b1;
    @(negedge clk);
    check("abort_cs",     32'(bus.qspi_cs),    32'h1);
    check("abort_sck",    32'(bus.qspi_sck),   32'h0);
    check("abort_dq0",    32'(qspi_dq[0]),     32'h0);
    check("abort_gpio",   gpio,                32'h0);
    check("abort_padrst", 32'(bus.pmu_padrst), 32'h1);
    check("abort_paden",  32'(bus.pmu_paden),  32'h0);
    mcu_rst = 1'b0;
    wait_done("reprobe");

    for (int i = 0; i < 5; i++) begin
      logic [23:0] rid;
      rid = 24'($urandom());
      case (i)
        1:       start_probe(1'b0, rid);
        2:       start_probe(1'b1, 24'h000000);
        default: start_probe(1'b1, rid);
      endcase
      wait_done($sformatf("probe%0d", i));
    end
    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb_q.size()), 32'h0);
    check("mosi_stable_while_sck_high", 32'(mosi_viol), 32'h0);

    // Wakeup pulse, then JTAG bypass at 10 MHz TCK.
    bus.mcu_wakeup = 1'b1;
    repeat (3) @(negedge clk);
    bus.mcu_wakeup = 1'b0;
    repeat (5) @(negedge clk);
    check("wakeup_set", 32'(gpio[31]), 32'h1);

    pat = 4'b1011;
    for (int i = 0; i <= 4; i++) begin
      bus.mcu_TCK = 1'b0;
      bus.mcu_TDI = (i < 4) ? pat[3 - i] : 1'b0;
      repeat (5) @(negedge clk);
      if (i > 0) check($sformatf("tdo_bit%0d", i - 1), 32'(bus.mcu_TDO), 32'(pat[3 - (i - 1)]));
      bus.mcu_TCK = 1'b1;
      repeat (5) @(negedge clk);
    end
    bus.mcu_TCK = 1'b0;
    repeat (5) @(negedge clk);
    check("tdo_only_after_fall", 32'(tdo_viol), 32'h0);
    check("wakeup_sticky", 32'(gpio[31]), 32'h1);

    // Free-run the LF clock and compare the rise count with the closed form.
    repeat (13000) @(negedge clk);
    @(posedge clk);
    #2;
    lf_exp = (longint'(lf_k_snap) * LF_INC + (64'd1 << 31)) >> 32;
    check("lf_edge_count", 32'(lf_edges), 32'(lf_exp));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
